// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl shared types and defaults.
// State encodings and default operand width.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester <-> serial adder handshake bundle.
// sub exists only with SERIAL_ADD_SUB_EN defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, c_in,
    input  sum, c_out, ovf, busy, done
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, c_in,
    output sum, c_out, ovf, busy, done
  );

endinterface

// File: rtl/serial_add_ctrl_adder.sv
// One-bit full-adder cell shared by the
// serial adder datapath.
module serial_add_ctrl_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic o,
  output logic c_out
);

  assign o     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller, LSB first.
// SERIAL_ADD_SUB_EN adds a subtract mode.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_o, fa_co;

  serial_add_ctrl_adder u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .c_in  (carry_q),
    .o     (fa_o),
    .c_out (fa_co)
  );

  // Next state and datapath update.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          sa_d    = bus.a;
          sb_d    = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
          if (bus.sub) begin
            sb_d    = ~bus.b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      ST_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = (WIDTH-1)'({fa_o, res_q} >> 1);
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = {fa_o, res_q};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl, WIDTH=8.
// Subtract steps run when SERIAL_ADD_SUB_EN is set.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta,
                        input logic [7:0] tb_,
                        input logic tc,
                        output int nbusy,
                        output int lat,
                        output logic ok);
    @(negedge clk);
    bus.a = ta;
    bus.b = tb_;
    bus.c_in = tc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) nbusy++;
      lat++;
      @(negedge clk);
    end
    ok = (bus.done === 1'b1);
  endtask

  task automatic wait_done(output int t,
                           output logic ok);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.done === 1'b1);
    t = cyc;
  endtask

  initial begin
    int nb, lat, t1, t2, seen;
    logic ok;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    #2;
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_cout", 32'(bus.c_out), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h33, 1'b0, nb, lat, ok);
    check("op1_done", 32'(ok), 1);
    check("op1_lat", lat, 8);
    check("op1_busy", nb, 8);
    check("op1_sum", 32'(bus.sum), 32'h8D);
    check("op1_cout", 32'(bus.c_out), 0);
    check("op1_ovf", 32'(bus.ovf), 1);
    @(negedge clk);
    check("op1_pulse", 32'(bus.done), 0);
    check("op1_hold", 32'(bus.sum), 32'h8D);

    run_op(8'hFF, 8'h01, 1'b0, nb, lat, ok);
    check("op2_done", 32'(ok), 1);
    check("op2_sum", 32'(bus.sum), 0);
    check("op2_cout", 32'(bus.c_out), 1);
    check("op2_ovf", 32'(bus.ovf), 0);

    run_op(8'h00, 8'h00, 1'b1, nb, lat, ok);
    check("op3_done", 32'(ok), 1);
    check("op3_sum", 32'(bus.sum), 1);
    check("op3_cout", 32'(bus.c_out), 0);

    run_op(8'h80, 8'h80, 1'b0, nb, lat, ok);
    check("op4_done", 32'(ok), 1);
    check("op4_busy", nb, 8);
    check("op4_sum", 32'(bus.sum), 0);
    check("op4_cout", 32'(bus.c_out), 1);
    check("op4_ovf", 32'(bus.ovf), 1);

    @(negedge clk);
    bus.a = 8'h01;
    bus.b = 8'h01;
    bus.c_in = 1'b0;
    bus.start = 1'b1;
    wait_done(t1, ok);
    check("held1_done", 32'(ok), 1);
    check("held1_sum", 32'(bus.sum), 2);
    repeat (3) @(negedge clk);
    check("held_busy", 32'(bus.busy), 1);
    bus.a = 8'h7F;
    wait_done(t2, ok);
    bus.start = 1'b0;
    bus.a = 8'h00;
    check("held2_done", 32'(ok), 1);
    check("held_gap", t2 - t1, 10);
    check("held2_sum", 32'(bus.sum), 2);
    @(negedge clk);
    check("held_pulse", 32'(bus.done), 0);

    @(negedge clk);
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(bus.sum), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check("arst_nodone", seen, 0);
    run_op(8'h12, 8'h34, 1'b0, nb, lat, ok);
    check("post_done", 32'(ok), 1);
    check("post_lat", lat, 8);
    check("post_sum", 32'(bus.sum), 32'h46);
    check("post_ovf", 32'(bus.ovf), 0);

`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, nb, lat, ok);
    check("sub1_done", 32'(ok), 1);
    check("sub1_sum", 32'(bus.sum), 32'h0F);
    check("sub1_cout", 32'(bus.c_out), 1);
    run_op(8'h00, 8'h01, 1'b1, nb, lat, ok);
    check("sub2_done", 32'(ok), 1);
    check("sub2_sum", 32'(bus.sum), 32'hFF);
    check("sub2_cout", 32'(bus.c_out), 0);
    bus.sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
